// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states and word geometry.
// The checksum option (IMEM_LOADER_CHECKSUM_EN) adds the CHECK state's behaviour.
package imem_loader_pkg;

  localparam int DEFAULT_ADDR_W = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Big-endian word assembler: the first byte shifted in ends up in bits [31:24].
// word_full flags the shift that completes a word.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_out,
  output logic        word_full
);

  logic [BYTE_CNT_W-1:0] count_q, count_d;
  logic [31:0]           word_q, word_d;

  always_comb begin
    count_d = count_q;
    word_d  = word_q;
    if (clear) begin
      count_d = '0;
    end else if (shift_en) begin
      count_d = count_q + 1'b1;
      word_d  = {word_q[23:0], byte_in};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      word_q  <= '0;
    end else begin
      count_q <= count_d;
      word_q  <= word_d;
    end
  end

  assign word_out  = word_q;
  assign word_full = shift_en && (count_q == BYTE_CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Loads instruction memory from a byte stream while holding the CPU in reset.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_words,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] num_words_q, num_words_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] last_addr;
  logic              asm_clear, asm_shift, word_full;
  logic [31:0]       word;
  logic              accept;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
  logic       err_q, err_d;
`endif

  assign last_addr = num_words_q - 1'b1;
  assign accept    = byte_valid && byte_ready;

  always_comb begin
    state_d     = state_q;
    num_words_d = num_words_q;
    addr_d      = addr_q;
    asm_clear   = 1'b0;
    asm_shift   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
    err_d       = err_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          num_words_d = num_words;
          addr_d      = '0;
          asm_clear   = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d      = '0;
          err_d       = 1'b0;
`endif
          state_d     = (num_words == '0) ? ST_DONE : ST_RECV;
        end
      end
      ST_RECV: begin
        asm_shift = accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (accept) csum_d = csum_q ^ byte_data;
`endif
        if (word_full) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (addr_q == last_addr) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = ST_CHECK;
`else
          state_d = ST_DONE;
`endif
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = ST_RECV;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (accept) begin
          err_d   = (byte_data != csum_q);
          state_d = ST_DONE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      num_words_q <= '0;
      addr_q      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      num_words_q <= num_words_d;
      addr_q      <= addr_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
      err_q       <= err_d;
`endif
    end
  end

  word_assembler u_word_assembler (
    .clk       (clk),
    .reset     (reset),
    .clear     (asm_clear),
    .shift_en  (asm_shift),
    .byte_in   (byte_data),
    .word_out  (word),
    .word_full (word_full)
  );

  // Outputs decode only registered state, so byte_valid never reaches byte_ready.
  assign byte_ready = (state_q == ST_RECV) || (state_q == ST_CHECK);
  assign mem_we     = (state_q == ST_WRITE);
  assign busy       = (state_q == ST_RECV) || (state_q == ST_WRITE) || (state_q == ST_CHECK);
  assign done       = (state_q == ST_DONE);
  assign mem_addr   = addr_q;
  assign mem_wdata  = word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign err        = err_q;
`else
  assign err        = 1'b0;
`endif
  assign cpu_reset  = !((state_q == ST_DONE) && !err);

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as bytes are driven
// and checked against mem_we cycles; optional checksum scenarios follow IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset, start, byte_valid;
  logic [ADDR_W-1:0] num_words;
  logic [7:0]        byte_data;
  logic              byte_ready, mem_we, cpu_reset, busy, done, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } write_t;

  write_t      expQ[$];
  logic [31:0] wordList[8];
  logic [7:0]  csumFlip;
  int compareCount = 0;
  int mismatchCount = 0;
  int writeCount = 0;
  int readyDrops = 0;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num_words  (num_words),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
    end
  endtask

  // Every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin : monitor
    write_t e;
    if (!reset) begin
      if (mem_we) begin
        writeCount++;
        if (expQ.size() == 0) begin
          checkOutput("unexpected_we", 32'd1, 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("we_addr", 32'(mem_addr), 32'(e.addr));
          checkOutput("we_data", mem_wdata, e.data);
        end
      end
      if (busy && (byte_ready == mem_we)) readyDrops++;
    end
  end

  task automatic applyStimulus(input logic [7:0] b, input int gap);
    int waitCycles = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && waitCycles < 100) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!byte_ready) begin
      checkOutput("byte_timeout", 32'd0, 32'd1);
      byte_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic startSession(input logic [ADDR_W-1:0] n);
    @(negedge clk);
    start     = 1'b1;
    num_words = n;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic loadWords(input int n, input int firstByte, input int gap);
    write_t     w;
    logic [7:0] csum = 8'h00;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        logic [7:0] b;
        b = wordList[i][31-8*k -: 8];
        csum = csum ^ b;
        if (i == 0 && k < firstByte) continue;
        if (k == 3) begin
          w.addr = ADDR_W'(i);
          w.data = wordList[i];
          expQ.push_back(w);
        end
        applyStimulus(b, gap);
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    applyStimulus(csum ^ csumFlip, gap);
`else
    if (csum === 8'hxx) checkOutput("csum_x", 32'd0, 32'd1);
`endif
  endtask

  task automatic waitDone();
    int c = 0;
    while (!done && c < 200) begin
      @(negedge clk);
      c++;
    end
    checkOutput("done", 32'(done), 32'd1);
    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    checkOutput({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    checkOutput({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int wBefore;
    reset = 1'b1; start = 1'b0; num_words = '0; byte_valid = 1'b0; byte_data = 8'h00;
    csumFlip = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("rst");
    @(negedge clk);
    reset = 1'b0;

    // Two identical words, back-to-back bytes.
    wordList[0] = 32'h20310005; wordList[1] = 32'h20310005;
    startSession(2);
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    checkOutput("cpu_reset_loading", 32'(cpu_reset), 32'd1);
    loadWords(2, 0, 0);
    waitDone();
    checkOutput("s1_cpu_reset", 32'(cpu_reset), 32'd0);
    checkOutput("s1_busy", 32'(busy), 32'd0);
    checkOutput("s1_err", 32'(err), 32'd0);
    checkOutput("s1_writes", 32'(writeCount), 32'd2);

    // Distinct words with byte_valid every other cycle, restarted from DONE.
    wordList[0] = 32'h8E370004; wordList[1] = 32'h12345678; wordList[2] = 32'hDEADBEEF;
    wBefore = writeCount;
    startSession(3);
    checkOutput("s2_done_cleared", 32'(done), 32'd0);
    loadWords(3, 0, 1);
    waitDone();
    checkOutput("s2_writes", 32'(writeCount - wBefore), 32'd3);
    checkOutput("s2_ready_drops", 32'(readyDrops), 32'd0);
    checkOutput("s2_cpu_reset", 32'(cpu_reset), 32'd0);

    // Reset in the middle of the first word.
    startSession(2);
    applyStimulus(8'h20, 0);
    applyStimulus(8'h31, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkResetOutputs("midrst");
    @(negedge clk);
    reset = 1'b0;
    wordList[0] = 32'hCAFEF00D;
    startSession(1);
    loadWords(1, 0, 0);
    waitDone();

    // Zero-length session from IDLE.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wBefore = writeCount;
    startSession(0);
    checkOutput("zero_done", 32'(done), 32'd1);
    checkOutput("zero_cpu_reset", 32'(cpu_reset), 32'd0);
    checkOutput("zero_busy", 32'(busy), 32'd0);
    repeat (4) @(negedge clk);
    checkOutput("zero_writes", 32'(writeCount - wBefore), 32'd0);

    // start during RECV must be ignored, including its num_words.
    wordList[0] = 32'h01020304; wordList[1] = 32'hA5A55A5A;
    wBefore = writeCount;
    startSession(2);
    applyStimulus(8'h01, 0);
    @(negedge clk);
    start = 1'b1; num_words = 8'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("ign_busy", 32'(busy), 32'd1);
    loadWords(2, 1, 0);
    waitDone();
    checkOutput("ign_writes", 32'(writeCount - wBefore), 32'd2);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum: correct byte, then a corrupted one.
    wordList[0] = 32'h8E370004;
    csumFlip = 8'h00;
    startSession(1);
    loadWords(1, 0, 0);
    waitDone();
    checkOutput("csum_ok_err", 32'(err), 32'd0);
    checkOutput("csum_ok_cpu_reset", 32'(cpu_reset), 32'd0);
    csumFlip = 8'hFF;
    startSession(1);
    loadWords(1, 0, 0);
    waitDone();
    checkOutput("csum_bad_err", 32'(err), 32'd1);
    checkOutput("csum_bad_cpu_reset", 32'(cpu_reset), 32'd1);
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
